// File: rtl/tcp_pkg.sv
// tcp_pkg: constants shared by the TCP receive path.
//   - 5-bit connection states, same encoding as tcp_control.state_out
//   - TCP flag bit positions inside header byte 13
//   - header byte offsets and the minimum header length
//   - tcp_rx_parser FSM state encodings
//   - ones_add16: 16-bit one's-complement add with end-around carry
package tcp_pkg;

  // Connection states (shared with tcp_control)
  localparam logic [4:0] TCP_CLOSED     = 5'h00;
  localparam logic [4:0] TCP_LISTEN     = 5'h01;
  localparam logic [4:0] TCP_SYN_SENT   = 5'h02;
  localparam logic [4:0] TCP_SYN_RCVD   = 5'h03;
  localparam logic [4:0] TCP_ESTAB      = 5'h04;
  localparam logic [4:0] TCP_FIN_WAIT_1 = 5'h05;
  localparam logic [4:0] TCP_FIN_WAIT_2 = 5'h06;
  localparam logic [4:0] TCP_CLOSING    = 5'h07;
  localparam logic [4:0] TCP_TIME_WAIT  = 5'h08;
  localparam logic [4:0] TCP_LAST_ACK   = 5'h09;
  localparam logic [4:0] TCP_CLOSE_WAIT = 5'h0A;

  // Flag bit indices within the flags byte
  localparam int TCP_FLAG_FIN = 0;
  localparam int TCP_FLAG_SYN = 1;
  localparam int TCP_FLAG_RST = 2;
  localparam int TCP_FLAG_PSH = 3;
  localparam int TCP_FLAG_ACK = 4;
  localparam int TCP_FLAG_URG = 5;

  // Header byte offsets (first byte of each field)
  localparam logic [15:0] OFF_SRC_PORT = 16'd0;
  localparam logic [15:0] OFF_DST_PORT = 16'd2;
  localparam logic [15:0] OFF_SEQ      = 16'd4;
  localparam logic [15:0] OFF_ACK      = 16'd8;
  localparam logic [15:0] OFF_DOFF     = 16'd12;
  localparam logic [15:0] OFF_FLAGS    = 16'd13;
  localparam logic [15:0] OFF_WINDOW   = 16'd14;
  localparam logic [15:0] OFF_CSUM     = 16'd16;
  localparam logic [15:0] OFF_HDR_LAST = 16'd19;

  localparam int TCP_MIN_HLEN = 20;

  // tcp_rx_parser FSM
  localparam logic [2:0] RX_IDLE = 3'd0;
  localparam logic [2:0] RX_HDR  = 3'd1;
  localparam logic [2:0] RX_OPT  = 3'd2;
  localparam logic [2:0] RX_PAY  = 3'd3;
  localparam logic [2:0] RX_DROP = 3'd4;

  // The 17-bit sum's carry is folded back in; a second carry cannot occur.
  function automatic logic [15:0] ones_add16(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[15:0] + {15'd0, s[16]};
  endfunction

endpackage

// File: rtl/tcp_csum_acc.sv
// tcp_csum_acc: byte-serial one's-complement 16-bit accumulator.
// Bytes are paired big-endian into 16-bit words. sum_o is the folded sum of
// every byte up to and including the current byte_i, with an unpaired final
// byte padded by 0x00, so the owner can judge the segment on its last beat.
// Ports:
//   clk, rst_n   clock, async active-low reset
//   valid_i      byte_i is a beat to accumulate
//   start_i      byte_i is the first byte of a segment (restart from init_i)
//   init_i       starting value (pseudo-header sum)
//   byte_i       data byte
//   sum_o        folded sum including byte_i
module tcp_csum_acc
  import tcp_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_i,
  input  logic        start_i,
  input  logic [15:0] init_i,
  input  logic [7:0]  byte_i,
  output logic [15:0] sum_o
);

  logic [15:0] sum_q;
  logic [7:0]  hi_q;
  logic        odd_q;     // a high byte is waiting for its partner
  logic [15:0] sum_base;
  logic        odd_base;
  logic [15:0] word;

  always_comb begin
    sum_base = start_i ? init_i : sum_q;
    odd_base = start_i ? 1'b0 : odd_q;
    word     = odd_base ? {hi_q, byte_i} : {byte_i, 8'h00};
    sum_o    = ones_add16(sum_base, word);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q <= 16'h0000;
      hi_q  <= 8'h00;
      odd_q <= 1'b0;
    end else if (valid_i) begin
      if (odd_base) begin
        sum_q <= sum_o;
        odd_q <= 1'b0;
      end else begin
        // High byte only held; the padded sum is not committed.
        sum_q <= sum_base;
        hi_q  <= byte_i;
        odd_q <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/tcp_rx_parser.sv
// tcp_rx_parser: receive-side TCP header parser feeding tcp_control.
// Consumes one segment per packet (IP header already stripped), captures
// header fields by byte offset, filters on ports, and at the s_tlast beat
// emits registered single-cycle event pulses plus latched SEQ/ACK/WINDOW and
// payload length of the last accepted segment (one cycle after s_tlast).
// Optional build macro: TCP_RX_CHECKSUM_EN adds checksum verification via
// tcp_csum_acc seeded with pseudo_sum; undefined, pseudo_sum is ignored.
//
// Handshake: a beat is s_tvalid & s_tready. s_tready is 0 in reset and 1
// from the first clock edge after release; the parser never stalls.
//
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   s_tdata/s_tvalid/s_tlast/s_tready  segment byte stream
//   local_port, remote_port         port filter (dst / src)
//   expected_ack                    SND.NXT, sampled at s_tlast
//   state_in                        tcp_control state, sampled at s_tlast
//   pseudo_sum                      pseudo-header sum (checksum build only)
//   syn_rcvd .. rst_rcvd            event pulses
//   seg_drop                        segment discarded pulse
//   rcv_seq/rcv_ack/rcv_window      fields of last accepted segment
//   payload_len                     payload bytes of last accepted segment
//   hdr_valid                       pulse with the event pulses
//   dbg_state                       parser FSM state
module tcp_rx_parser
  import tcp_pkg::*;
#(
  parameter int MAX_SEG_LEN = 1480
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  s_tdata,
  input  logic        s_tvalid,
  input  logic        s_tlast,
  output logic        s_tready,
  input  logic [15:0] local_port,
  input  logic [15:0] remote_port,
  input  logic [31:0] expected_ack,
  input  logic [4:0]  state_in,
  input  logic [15:0] pseudo_sum,
  output logic        syn_rcvd,
  output logic        syn_ack_rcvd,
  output logic        ack_rcvd,
  output logic        fin_rcvd,
  output logic        fin_ack_rcvd,
  output logic        rst_rcvd,
  output logic        seg_drop,
  output logic [31:0] rcv_seq,
  output logic [31:0] rcv_ack,
  output logic [15:0] rcv_window,
  output logic [15:0] payload_len,
  output logic        hdr_valid,
  output logic [2:0]  dbg_state
);

  localparam logic [16:0] MAX_LEN = 17'(MAX_SEG_LEN);

  logic        rdy_q;
  logic [2:0]  state_q, state_d;
  logic [15:0] bcnt_q, bcnt_d;

  // Header shadow registers, filled as bytes pass
  logic [15:0] src_q, dst_q, win_q;
  logic [31:0] seq_q, ack_q;
  logic [3:0]  doff_q;
  logic [7:0]  flags_q;

  // Output registers
  logic        syn_q, syn_ack_q, ack_ev_q, fin_q, fin_ack_q, rst_q, drop_q, hv_q;
  logic [31:0] rcv_seq_q, rcv_ack_q;
  logic [15:0] rcv_win_q, plen_q;

  logic        beat, last;
  logic [5:0]  hlen;
  logic [16:0] seg_len;
  logic        csum_ok, accept, do_eval, do_drop;
  logic        f_fin, f_syn, f_rst, f_ack, ack_ok, ack_ev, closing_st;

  assign beat = s_tvalid & rdy_q;
  assign last = beat & s_tlast;

  assign hlen    = {doff_q, 2'b00};
  assign seg_len = {1'b0, bcnt_q} + 17'd1;

`ifdef TCP_RX_CHECKSUM_EN
  logic [15:0] csum_sum;
  tcp_csum_acc u_csum (
    .clk     (clk),
    .rst_n   (rst_n),
    .valid_i (beat),
    .start_i (state_q == RX_IDLE),
    .init_i  (pseudo_sum),
    .byte_i  (s_tdata),
    .sum_o   (csum_sum)
  );
  assign csum_ok = (csum_sum == 16'hFFFF);
`else
  logic unused_pseudo;
  assign unused_pseudo = ^pseudo_sum;
  assign csum_ok = 1'b1;
`endif

  logic unused_flags;
  assign unused_flags = ^{flags_q[7:5], flags_q[3]};

  // Saturated counter means the true length is unknown: never accept.
  assign accept = (dst_q == local_port) && (src_q == remote_port) &&
                  (seg_len >= {11'd0, hlen}) && (seg_len <= MAX_LEN) &&
                  (bcnt_q != 16'hFFFF) && csum_ok;

  // Byte counter
  always_comb begin
    bcnt_d = bcnt_q;
    if (last)
      bcnt_d = 16'd0;
    else if (beat && bcnt_q != 16'hFFFF)
      bcnt_d = bcnt_q + 16'd1;
  end

  // FSM; every s_tlast beat either evaluates or drops, and returns to IDLE
  always_comb begin
    state_d = state_q;
    do_eval = 1'b0;
    do_drop = 1'b0;
    if (beat) begin
      case (state_q)
        RX_IDLE: begin
          if (s_tlast) do_drop = 1'b1;
          else         state_d = RX_HDR;
        end
        RX_HDR: begin
          if (s_tlast) begin
            state_d = RX_IDLE;
            if (bcnt_q < OFF_HDR_LAST) do_drop = 1'b1;
            else                       do_eval = 1'b1;
          end else if (bcnt_q == OFF_DOFF && s_tdata[7:4] < 4'd5) begin
            state_d = RX_DROP;
          end else if (bcnt_q == OFF_HDR_LAST) begin
            state_d = (hlen > 6'(TCP_MIN_HLEN)) ? RX_OPT : RX_PAY;
          end
        end
        RX_OPT: begin
          // A short options area is caught by the length test in accept.
          if (s_tlast) begin
            state_d = RX_IDLE;
            do_eval = 1'b1;
          end else if (bcnt_q == {10'd0, hlen} - 16'd1) begin
            state_d = RX_PAY;
          end
        end
        RX_PAY: begin
          if (s_tlast) begin
            state_d = RX_IDLE;
            do_eval = 1'b1;
          end
        end
        RX_DROP: begin
          if (s_tlast) begin
            state_d = RX_IDLE;
            do_drop = 1'b1;
          end
        end
        default: state_d = RX_IDLE;
      endcase
    end
  end

  // Flag decode
  assign f_fin  = flags_q[TCP_FLAG_FIN];
  assign f_syn  = flags_q[TCP_FLAG_SYN];
  assign f_rst  = flags_q[TCP_FLAG_RST];
  assign f_ack  = flags_q[TCP_FLAG_ACK];
  assign ack_ok = (ack_q == expected_ack);
  assign ack_ev = ~f_syn & f_ack & ack_ok;
  assign closing_st = (state_in == TCP_FIN_WAIT_1) || (state_in == TCP_CLOSING) ||
                      (state_in == TCP_LAST_ACK);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_q   <= 1'b0;
      state_q <= RX_IDLE;
      bcnt_q  <= 16'd0;
    end else begin
      rdy_q   <= 1'b1;
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
    end
  end

  // Header capture by offset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_q   <= 16'd0;
      dst_q   <= 16'd0;
      seq_q   <= 32'd0;
      ack_q   <= 32'd0;
      doff_q  <= 4'd0;
      flags_q <= 8'd0;
      win_q   <= 16'd0;
    end else if (beat) begin
      case (bcnt_q)
        OFF_SRC_PORT:          src_q[15:8]   <= s_tdata;
        OFF_SRC_PORT + 16'd1:  src_q[7:0]    <= s_tdata;
        OFF_DST_PORT:          dst_q[15:8]   <= s_tdata;
        OFF_DST_PORT + 16'd1:  dst_q[7:0]    <= s_tdata;
        OFF_SEQ:               seq_q[31:24]  <= s_tdata;
        OFF_SEQ + 16'd1:       seq_q[23:16]  <= s_tdata;
        OFF_SEQ + 16'd2:       seq_q[15:8]   <= s_tdata;
        OFF_SEQ + 16'd3:       seq_q[7:0]    <= s_tdata;
        OFF_ACK:               ack_q[31:24]  <= s_tdata;
        OFF_ACK + 16'd1:       ack_q[23:16]  <= s_tdata;
        OFF_ACK + 16'd2:       ack_q[15:8]   <= s_tdata;
        OFF_ACK + 16'd3:       ack_q[7:0]    <= s_tdata;
        OFF_DOFF:              doff_q        <= s_tdata[7:4];
        OFF_FLAGS:             flags_q       <= s_tdata;
        OFF_WINDOW:            win_q[15:8]   <= s_tdata;
        OFF_WINDOW + 16'd1:    win_q[7:0]    <= s_tdata;
        default: ;
      endcase
    end
  end

  // Registered results: pulses default low every cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      syn_q     <= 1'b0;
      syn_ack_q <= 1'b0;
      ack_ev_q  <= 1'b0;
      fin_q     <= 1'b0;
      fin_ack_q <= 1'b0;
      rst_q     <= 1'b0;
      drop_q    <= 1'b0;
      hv_q      <= 1'b0;
      rcv_seq_q <= 32'd0;
      rcv_ack_q <= 32'd0;
      rcv_win_q <= 16'd0;
      plen_q    <= 16'd0;
    end else begin
      syn_q     <= 1'b0;
      syn_ack_q <= 1'b0;
      ack_ev_q  <= 1'b0;
      fin_q     <= 1'b0;
      fin_ack_q <= 1'b0;
      rst_q     <= 1'b0;
      drop_q    <= do_drop | (do_eval & ~accept);
      hv_q      <= 1'b0;
      if (do_eval && accept) begin
        hv_q      <= 1'b1;
        rcv_seq_q <= seq_q;
        rcv_ack_q <= ack_q;
        rcv_win_q <= win_q;
        plen_q    <= bcnt_q + 16'd1 - {10'd0, hlen};
        if (f_rst) begin
          rst_q <= 1'b1;
        end else begin
          syn_q     <= f_syn;
          syn_ack_q <= f_syn & f_ack & ack_ok;
          ack_ev_q  <= ack_ev;
          fin_q     <= f_fin & ~f_syn;
          fin_ack_q <= ack_ev & closing_st;
        end
      end
    end
  end

  assign s_tready     = rdy_q;
  assign syn_rcvd     = syn_q;
  assign syn_ack_rcvd = syn_ack_q;
  assign ack_rcvd     = ack_ev_q;
  assign fin_rcvd     = fin_q;
  assign fin_ack_rcvd = fin_ack_q;
  assign rst_rcvd     = rst_q;
  assign seg_drop     = drop_q;
  assign hdr_valid    = hv_q;
  assign rcv_seq      = rcv_seq_q;
  assign rcv_ack      = rcv_ack_q;
  assign rcv_window   = rcv_win_q;
  assign payload_len  = plen_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_tcp_rx_parser.sv
// Bench for tcp_rx_parser: table of segments driven back-to-back, expected
// pulse/field vectors queued at the s_tlast beat and compared one cycle later.
module tb_tcp_rx_parser;

  localparam int W = 104;
  localparam logic [15:0] LP = 16'h1F90;
  localparam logic [15:0] RP = 16'h0050;
  localparam logic [15:0] PSEUDO = 16'h1234;

  // Clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0]  s_tdata = 8'h00;
  logic        s_tvalid = 1'b0, s_tlast = 1'b0, s_tready;
  logic [31:0] expected_ack = 32'd0;
  logic [4:0]  state_in = 5'd0;
  logic        syn_rcvd, syn_ack_rcvd, ack_rcvd, fin_rcvd, fin_ack_rcvd, rst_rcvd;
  logic        seg_drop, hdr_valid;
  logic [31:0] rcv_seq, rcv_ack;
  logic [15:0] rcv_window, payload_len;
  logic [2:0]  dbg_state;

  tcp_rx_parser #(.MAX_SEG_LEN(1480)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
    .local_port(LP), .remote_port(RP), .expected_ack(expected_ack),
    .state_in(state_in), .pseudo_sum(PSEUDO),
    .syn_rcvd(syn_rcvd), .syn_ack_rcvd(syn_ack_rcvd), .ack_rcvd(ack_rcvd),
    .fin_rcvd(fin_rcvd), .fin_ack_rcvd(fin_ack_rcvd), .rst_rcvd(rst_rcvd),
    .seg_drop(seg_drop), .rcv_seq(rcv_seq), .rcv_ack(rcv_ack),
    .rcv_window(rcv_window), .payload_len(payload_len), .hdr_valid(hdr_valid),
    .dbg_state(dbg_state)
  );

  // exp_p bit order: {rst, syn, syn_ack, ack, fin, fin_ack, drop, hdr_valid}
  typedef struct {
    logic [15:0] src, dst;
    logic [31:0] seq, ack;
    logic [3:0]  doff;
    logic [7:0]  flags;
    logic [15:0] win;
    int          plen, trunc;
    bit          flip, gaps;
    logic [31:0] exp_ack;
    logic [4:0]  st;
    logic [7:0]  exp_p;
  } vec_t;

  // Scoreboard
  logic [W-1:0] exp_q[$];
  int           due_q[$];
  int checks = 0, errors = 0;
  logic [31:0] m_seq = 0, m_ack = 0;
  logic [15:0] m_win = 0, m_plen = 0;
  logic [7:0]  seg_bytes [0:2047];

  function automatic logic [W-1:0] act_vec();
    return {rst_rcvd, syn_rcvd, syn_ack_rcvd, ack_rcvd, fin_rcvd, fin_ack_rcvd,
            seg_drop, hdr_valid, rcv_seq, rcv_ack, rcv_window, payload_len};
  endfunction

  task automatic check_v(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (due_q.size() > 0 && due_q[0] == cyc) begin
        void'(due_q.pop_front());
        check_v("seg_result", act_vec(), exp_q.pop_front());
      end else if (act_vec() >> 96 != 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse actual=%h required=00 at cycle %0d", act_vec() >> 96, cyc);
      end
    end
  end

  task automatic push_exp(input vec_t v);
    if (v.exp_p[0]) begin
      m_seq = v.seq; m_ack = v.ack; m_win = v.win; m_plen = 16'(v.plen);
    end
    exp_q.push_back({v.exp_p, m_seq, m_ack, m_win, m_plen});
    due_q.push_back(cyc + 1);
  endtask

  // Driver: builds the segment with a valid checksum, then streams it.
  // abort_at > 0 sends only that many bytes and no s_tlast.
  task automatic send_seg(input vec_t v, input int abort_at);
    int hl, n, nsend;
    logic [31:0] s;
    logic [15:0] cs;
    hl = (v.doff >= 4'd5) ? int'(v.doff) * 4 : 20;
    n  = hl + v.plen;
    for (int i = 0; i < n; i++) seg_bytes[i] = 8'h00;
    seg_bytes[0] = v.src[15:8];  seg_bytes[1] = v.src[7:0];
    seg_bytes[2] = v.dst[15:8];  seg_bytes[3] = v.dst[7:0];
    for (int i = 0; i < 4; i++) begin
      seg_bytes[4 + i] = 8'(v.seq >> (24 - 8 * i));
      seg_bytes[8 + i] = 8'(v.ack >> (24 - 8 * i));
    end
    seg_bytes[12] = {v.doff, 4'h0};
    seg_bytes[13] = v.flags;
    seg_bytes[14] = v.win[15:8]; seg_bytes[15] = v.win[7:0];
    for (int i = 20; i < hl; i++) seg_bytes[i] = 8'h01;
    for (int i = hl; i < n; i++) seg_bytes[i] = 8'($urandom_range(0, 255));
    s = {16'd0, PSEUDO};
    for (int i = 0; i < n; i += 2)
      s += {16'd0, seg_bytes[i], (i + 1 < n) ? seg_bytes[i + 1] : 8'h00};
    while (s[31:16] != 16'd0) s = {16'd0, s[15:0]} + {16'd0, s[31:16]};
    cs = ~s[15:0];
    seg_bytes[16] = cs[15:8]; seg_bytes[17] = cs[7:0];
    if (v.flip) seg_bytes[hl] = seg_bytes[hl] ^ 8'h01;
    nsend = (abort_at > 0) ? abort_at : ((v.trunc > 0) ? v.trunc : n);
    expected_ack = v.exp_ack;
    state_in = v.st;
    for (int i = 0; i < nsend; i++) begin
      if (v.gaps && i > 0 && $urandom_range(0, 3) == 0) begin
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
      s_tdata  = seg_bytes[i];
      s_tvalid = 1'b1;
      s_tlast  = (abort_at == 0) && (i == nsend - 1);
      if (s_tlast) push_exp(v);
      @(posedge clk);
      #1;
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() > 0 && n < 20) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout actual=%0d_pending required=0", exp_q.size());
      exp_q.delete();
      due_q.delete();
    end
  endtask

  function automatic vec_t mk(input logic [15:0] src, input logic [15:0] dst,
                              input logic [31:0] ack, input logic [3:0] doff,
                              input logic [7:0] flags, input int plen, input int trunc,
                              input bit flip, input bit gaps, input logic [31:0] exp_ack,
                              input logic [4:0] st, input logic [7:0] exp_p);
    vec_t v;
    v.src = src; v.dst = dst; v.ack = ack; v.doff = doff; v.flags = flags;
    v.seq = $urandom(); v.win = 16'($urandom());
    v.plen = plen; v.trunc = trunc; v.flip = flip; v.gaps = gaps;
    v.exp_ack = exp_ack; v.st = st; v.exp_p = exp_p;
    return v;
  endfunction

  vec_t tbl[20];
  vec_t v;

  initial begin
    #1_000_000;
    errors++;
    $display("FAIL global_timeout actual=running required=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_v("reset_outputs", act_vec(), '0);
    check_v("reset_tready", W'(s_tready), W'(0));
    rst_n = 1'b1;
    #1;
    check_v("tready_before_edge", W'(s_tready), W'(0));
    @(posedge clk);
    #1;
    check_v("tready_after_edge", W'(s_tready), W'(1));

    //            src   dst      ack           doff flags plen trunc flip gaps exp_ack      st     exp_p
    tbl[0]  = mk(RP, LP,       32'h00001001, 5, 8'h12, 0,    0,  0, 0, 32'h00001001, 5'h02, 8'b0110_0001);
    tbl[1]  = mk(RP, LP,       32'h00002000, 8, 8'h10, 100,  0,  0, 1, 32'h00002000, 5'h04, 8'b0001_0001);
    tbl[2]  = mk(RP, LP,       32'h00003000, 5, 8'h11, 10,   0,  0, 0, 32'h00003000, 5'h05, 8'b0001_1101);
    tbl[3]  = mk(RP, LP,       32'h00003000, 5, 8'h11, 10,   0,  0, 0, 32'h00003000, 5'h04, 8'b0001_1001);
    tbl[4]  = mk(RP, LP,       32'h00004000, 5, 8'h10, 5,    0,  0, 0, 32'h00004001, 5'h04, 8'b0000_0001);
    tbl[5]  = mk(RP, 16'h1F91, 32'h00004000, 5, 8'h10, 4,    0,  0, 0, 32'h00004000, 5'h04, 8'b0000_0010);
    tbl[6]  = mk(RP, LP,       32'h00004000, 5, 8'h10, 4,    11, 0, 0, 32'h00004000, 5'h04, 8'b0000_0010);
    tbl[7]  = mk(RP, LP,       32'h00004000, 3, 8'h10, 8,    0,  0, 0, 32'h00004000, 5'h04, 8'b0000_0010);
    tbl[8]  = mk(RP, LP,       32'h00005000, 5, 8'h02, 0,    0,  0, 0, 32'h00005000, 5'h01, 8'b0100_0001);
    tbl[9]  = mk(RP, LP,       32'h00005000, 5, 8'h14, 0,    0,  0, 0, 32'h00005000, 5'h04, 8'b1000_0001);
    tbl[10] = mk(16'h0051, LP, 32'h00005000, 5, 8'h10, 0,    0,  0, 0, 32'h00005000, 5'h04, 8'b0000_0010);
    tbl[11] = mk(RP, LP,       32'h00006000, 5, 8'h10, 1461, 0,  0, 0, 32'h00006000, 5'h04, 8'b0000_0010);
    tbl[12] = mk(RP, LP,       32'h00006000, 5, 8'h11, 1460, 0,  0, 0, 32'h00006000, 5'h07, 8'b0001_1101);
    tbl[13] = mk(RP, LP,       32'h00006000, 5, 8'h10, 0,    1,  0, 0, 32'h00006000, 5'h04, 8'b0000_0010);
    tbl[14] = mk(RP, LP,       32'h00006000, 6, 8'h10, 0,    20, 0, 0, 32'h00006000, 5'h04, 8'b0000_0010);
    tbl[15] = mk(RP, LP,       32'h00006000, 8, 8'h10, 0,    25, 0, 0, 32'h00006000, 5'h04, 8'b0000_0010);
    tbl[16] = mk(RP, LP,       32'h00007000, 5, 8'h10, 4,    0,  1, 0, 32'h00007000, 5'h04, 8'b0001_0001);
`ifdef TCP_RX_CHECKSUM_EN
    tbl[16].exp_p = 8'b0000_0010;
`endif
    tbl[17] = mk(RP, LP,       32'h00008000, 5, 8'h11, 7,    0,  0, 1, 32'h00008000, 5'h09, 8'b0001_1101);
    tbl[18] = mk(RP, LP,       32'h00009000, 5, 8'h12, 0,    0,  0, 0, 32'h00009001, 5'h02, 8'b0100_0001);
    tbl[19] = mk(RP, LP,       32'h0000A000, 5, 8'h03, 3,    0,  0, 0, 32'h0000A000, 5'h04, 8'b0100_0001);

    for (int i = 0; i < 20; i++) send_seg(tbl[i], 0);
    drain();

    // Reset after byte 7 of a segment, then a clean segment
    v = mk(RP, LP, 32'h0000B000, 5, 8'h10, 6, 0, 0, 0, 32'h0000B000, 5'h04, 8'b0001_0001);
    send_seg(v, 8);
    rst_n = 1'b0;
    #1;
    check_v("tready_in_reset", W'(s_tready), W'(0));
    @(negedge clk);
    check_v("outputs_in_reset", act_vec(), '0);
    m_seq = 0; m_ack = 0; m_win = 0; m_plen = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_v("tready_after_reset", W'(s_tready), W'(1));
    v = mk(RP, LP, 32'h0000C000, 8, 8'h10, 9, 0, 0, 0, 32'h0000C000, 5'h04, 8'b0001_0001);
    send_seg(v, 0);
    drain();
    repeat (3) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
